// File: rtl/md_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: op codes, FSM states
// and small op-decode helpers.
package md_pkg;

    localparam int unsigned MD_WIDTH = 32;

    localparam logic [2:0] MD_MULT  = 3'b000;
    localparam logic [2:0] MD_MULTU = 3'b001;
    localparam logic [2:0] MD_DIV   = 3'b010;
    localparam logic [2:0] MD_DIVU  = 3'b011;
    localparam logic [2:0] MD_MTHI  = 3'b100;
    localparam logic [2:0] MD_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StSign = 2'd2
    } md_state_e;

    // Ops 000..011 run the iterative datapath; bit 1 selects divide, bit 0 unsigned.
    function automatic logic md_is_iter(input logic [2:0] op);
        return ~op[2];
    endfunction

    function automatic logic md_is_signed(input logic [2:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// Operand/result bundle between the EX stage and the multiply/divide unit.
interface ex_muldiv_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             ex_md_start;
    logic [2:0]       ex_md_op;
    logic [WIDTH-1:0] ex_a;
    logic [WIDTH-1:0] ex_alu_b;
    logic             ex_md_flush;
    logic             md_busy;
    logic             md_done;
    logic [WIDTH-1:0] md_hi;
    logic [WIDTH-1:0] md_lo;

    modport master (
        output ex_md_start, ex_md_op, ex_a, ex_alu_b, ex_md_flush,
        input  md_busy, md_done, md_hi, md_lo
    );

    modport slave (
        input  ex_md_start, ex_md_op, ex_a, ex_alu_b, ex_md_flush,
        output md_busy, md_done, md_hi, md_lo
    );
endinterface

// File: rtl/md_iter_core.sv
// Single radix-2 step: shift-add multiply or restoring shift-subtract divide.
// acc holds {upper, lower}: product/multiplier for mul, remainder/quotient for div.
module md_iter_core #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   opnd_i,
    input  logic               is_div_i,
    output logic [2*WIDTH-1:0] acc_o
);
    logic [WIDTH:0] mul_sum;
    logic [WIDTH:0] div_rem;
    logic [WIDTH:0] div_diff;

    always_comb begin
        mul_sum  = {1'b0, acc_i[2*WIDTH-1:WIDTH]}
                 + (acc_i[0] ? {1'b0, opnd_i} : {(WIDTH+1){1'b0}});
        div_rem  = acc_i[2*WIDTH-1:WIDTH-1];
        div_diff = div_rem - {1'b0, opnd_i};
        if (is_div_i) begin
            // Top bit of the difference is the borrow: set means restore.
            if (!div_diff[WIDTH]) begin
                acc_o = {div_diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
            end else begin
                acc_o = {div_rem[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_o = {mul_sum, acc_i[WIDTH-1:1]};
        end
    end
endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative 32-cycle mul/div unit beside the EX ALU; owns HI/LO and stalls EX via md_busy.
module ex_muldiv_unit
    import md_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH,
    parameter int unsigned CNT_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    ex_muldiv_unit_if.slave   md
);
    md_state_e            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d, acc_nxt;
    logic [WIDTH-1:0]     opnd_q, opnd_d;
    logic                 is_div_q, is_div_d;
    logic                 neg_q, neg_d;
    logic                 neg_rem_q, neg_rem_d;
    logic                 div0_q, div0_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 done_q, done_d;

    logic                 a_neg, b_neg;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix, rem_fix;

    md_iter_core #(.WIDTH(WIDTH)) u_core (
        .acc_i    (acc_q),
        .opnd_i   (opnd_q),
        .is_div_i (is_div_q),
        .acc_o    (acc_nxt)
    );

    assign a_neg = md_is_signed(md.ex_md_op) & md.ex_a[WIDTH-1];
    assign b_neg = md_is_signed(md.ex_md_op) & md.ex_alu_b[WIDTH-1];
    assign a_mag = a_neg ? -md.ex_a : md.ex_a;
    assign b_mag = b_neg ? -md.ex_alu_b : md.ex_alu_b;

    // Divide by zero keeps the all-ones quotient regardless of operand signs.
    assign prod_fix = neg_q ? -acc_q : acc_q;
    assign quo_fix  = (neg_q && !div0_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (md.ex_md_start) begin
                    if (md_is_iter(md.ex_md_op)) begin
                        is_div_d  = md.ex_md_op[1];
                        neg_d     = a_neg ^ b_neg;
                        neg_rem_d = a_neg;
                        div0_d    = (md.ex_alu_b == '0);
                        acc_d     = md.ex_md_op[1] ? {{WIDTH{1'b0}}, a_mag}
                                                   : {{WIDTH{1'b0}}, b_mag};
                        opnd_d    = md.ex_md_op[1] ? b_mag : a_mag;
                        cnt_d     = '0;
                        state_d   = StCalc;
                    end else if (md.ex_md_op == MD_MTHI) begin
                        hi_d = md.ex_a;
                    end else if (md.ex_md_op == MD_MTLO) begin
                        lo_d = md.ex_a;
                    end
                end
            end
            StCalc: begin
                acc_d = acc_nxt;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == '1) begin
                    state_d = StSign;
                end
            end
            StSign: begin
                if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        // Flush beats everything, including a same-cycle start or MTHI/MTLO.
        if (md.ex_md_flush) begin
            state_d = StIdle;
            cnt_d   = '0;
            hi_d    = hi_q;
            lo_d    = lo_q;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign md.md_busy = (state_q != StIdle);
    assign md.md_done = done_q;
    assign md.md_hi   = hi_q;
    assign md.md_lo   = lo_q;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: mul/div results, MTHI/MTLO, flush and async reset.
module tb_ex_muldiv_unit;
    import md_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    ex_muldiv_unit_if #(.WIDTH(32)) md_if ();

    ex_muldiv_unit u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .md    (md_if)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue op at a negedge; returns at the negedge right after the start edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic flush);
        md_if.ex_md_start = 1'b1;
        md_if.ex_md_op    = op;
        md_if.ex_a        = a;
        md_if.ex_alu_b    = b;
        md_if.ex_md_flush = flush;
        @(negedge clk);
        md_if.ex_md_start = 1'b0;
        md_if.ex_md_flush = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo);
        int n;
        logic [31:0] hi_before;
        hi_before = md_if.md_hi;
        issue(op, a, b, 1'b0);
        n = 0;
        while (md_if.md_busy && n < 100) begin
            n++;
            if (n == 16) check({tag, "_hold"}, 64'(md_if.md_hi), 64'(hi_before));
            @(negedge clk);
        end
        check({tag, "_busy_cycles"}, 64'(n), 64'd33);
        check({tag, "_done"}, 64'(md_if.md_done), 64'd1);
        check({tag, "_hi"}, 64'(md_if.md_hi), 64'(exp_hi));
        check({tag, "_lo"}, 64'(md_if.md_lo), 64'(exp_lo));
        @(negedge clk);
        check({tag, "_done_pulse"}, 64'(md_if.md_done), 64'd0);
    endtask

    initial begin
        logic [31:0] hi_s, lo_s;
        logic        saw_done;

        md_if.ex_md_start = 1'b0;
        md_if.ex_md_op    = 3'b000;
        md_if.ex_a        = '0;
        md_if.ex_alu_b    = '0;
        md_if.ex_md_flush = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(md_if.md_busy), 64'd0);
        check("rst_done", 64'(md_if.md_done), 64'd0);
        check("rst_hi", 64'(md_if.md_hi), 64'd0);
        check("rst_lo", 64'(md_if.md_lo), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("mult_m3x7", MD_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1);
        run_op("mult_minsq", MD_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0);
        run_op("div_m7d2", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_7dm2", MD_DIV, 32'd7, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFD);
        run_op("divu_7d0", MD_DIVU, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF);
        run_op("div_m7d0", MD_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
        run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
        run_op("divu_100d7", MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);

        // MTHI / MTLO in idle
        issue(MD_MTHI, 32'h1234_5678, 32'h0, 1'b0);
        check("mthi_hi", 64'(md_if.md_hi), 64'h1234_5678);
        check("mthi_lo", 64'(md_if.md_lo), 64'd14);
        check("mthi_busy", 64'(md_if.md_busy), 64'd0);
        check("mthi_done", 64'(md_if.md_done), 64'd0);
        issue(MD_MTLO, 32'h9ABC_DEF0, 32'h0, 1'b0);
        check("mtlo_lo", 64'(md_if.md_lo), 64'h9ABC_DEF0);
        check("mtlo_hi", 64'(md_if.md_hi), 64'h1234_5678);
        check("mtlo_busy", 64'(md_if.md_busy), 64'd0);
        check("mtlo_done", 64'(md_if.md_done), 64'd0);
        issue(3'b110, 32'hDEAD_BEEF, 32'h0, 1'b0);
        check("op110_hi", 64'(md_if.md_hi), 64'h1234_5678);
        check("op110_busy", 64'(md_if.md_busy), 64'd0);

        // Flush mid-divide
        hi_s = md_if.md_hi;
        lo_s = md_if.md_lo;
        issue(MD_DIVU, 32'd100, 32'd7, 1'b0);
        check("flush_busy_pre", 64'(md_if.md_busy), 64'd1);
        repeat (9) @(negedge clk);
        md_if.ex_md_flush = 1'b1;
        @(negedge clk);
        md_if.ex_md_flush = 1'b0;
        check("flush_busy", 64'(md_if.md_busy), 64'd0);
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (md_if.md_done) saw_done = 1'b1;
            @(negedge clk);
        end
        check("flush_no_done", 64'(saw_done), 64'd0);
        check("flush_hi", 64'(md_if.md_hi), 64'(hi_s));
        check("flush_lo", 64'(md_if.md_lo), 64'(lo_s));

        // Start and flush together
        issue(MD_MULT, 32'd3, 32'd4, 1'b1);
        check("sf_mult_busy", 64'(md_if.md_busy), 64'd0);
        issue(MD_MTHI, 32'hAAAA_5555, 32'h0, 1'b1);
        check("sf_mthi_hi", 64'(md_if.md_hi), 64'(hi_s));

        // Async reset mid-calc
        issue(MD_MULT, 32'd5, 32'd9, 1'b0);
        repeat (19) @(negedge clk);
        check("rstmid_busy_pre", 64'(md_if.md_busy), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstmid_busy", 64'(md_if.md_busy), 64'd0);
        check("rstmid_hi", 64'(md_if.md_hi), 64'd0);
        check("rstmid_lo", 64'(md_if.md_lo), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op("post_rst", MD_MULT, 32'd5, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 32'hFFFF_FFE2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
